// File: rtl/alu_control_sequencer.sv
// ============================================================================
// Module   : alu_control_sequencer
// Brief    : Micro-step sequencer for the 8-bit accumulator machine. Decodes
//            opcode, step and ALU flags into active-low control strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR,
  input  logic                    i_ENABLE,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic                    i_ZERO_FLAG,
  input  logic                    i_CARRY_FLAG,
  output logic                    o_PC_OUT_n,
  output logic                    o_PC_INC,
  output logic                    o_PC_LOAD_n,
  output logic                    o_MAR_IN_n,
  output logic                    o_RAM_OUT_n,
  output logic                    o_RAM_IN_n,
  output logic                    o_IR_IN_n,
  output logic                    o_IR_OUT_n,
  output logic                    o_A_IN_n,
  output logic                    o_A_OUT_n,
  output logic                    o_B_IN_n,
  output logic                    o_ALU_OUT_n,
  output logic                    o_SUB,
  output logic                    o_UPDATE_FLAGS_n,
  output logic                    o_OUT_IN_n,
  output logic                    o_HALTED,
  output logic [STEP_WIDTH-1:0]   o_STEP
);

  localparam logic [OPCODE_WIDTH-1:0] c_OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_SUB = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_STA = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_LDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_JMP = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_JC  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_JZ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_OUT = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] c_OP_HLT = OPCODE_WIDTH'(15);

  localparam logic [STEP_WIDTH-1:0] c_T0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] c_T1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] c_T2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] c_T3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] c_T4 = STEP_WIDTH'(4);

  logic [STEP_WIDTH-1:0] r_STEP;
  logic                  r_HALTED;
  logic [STEP_WIDTH-1:0] w_last_step;
  logic                  w_active;

  logic w_pc_out;
  logic w_pc_inc;
  logic w_pc_load;
  logic w_mar_in;
  logic w_ram_out;
  logic w_ram_in;
  logic w_ir_in;
  logic w_ir_out;
  logic w_a_in;
  logic w_a_out;
  logic w_b_in;
  logic w_alu_out;
  logic w_sub;
  logic w_update_flags;
  logic w_out_in;

  // Final micro-step of each instruction; undefined opcodes end at T2 like NOP.
  always_comb begin
    w_last_step = c_T2;
    case (i_OPCODE)
      c_OP_LDA, c_OP_STA: w_last_step = c_T3;
      c_OP_ADD, c_OP_SUB: w_last_step = c_T4;
      default:            w_last_step = c_T2;
    endcase
  end

  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      r_STEP   <= c_T0;
      r_HALTED <= 1'b0;
    end else if (i_ENABLE && !r_HALTED) begin
      if (r_STEP == c_T2 && i_OPCODE == c_OP_HLT) begin
        r_HALTED <= 1'b1;
      end else if (r_STEP >= w_last_step) begin
        // Also catches the unreachable codes 5..7.
        r_STEP <= c_T0;
      end else begin
        r_STEP <= r_STEP + STEP_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_pc_out       = 1'b0;
    w_pc_inc       = 1'b0;
    w_pc_load      = 1'b0;
    w_mar_in       = 1'b0;
    w_ram_out      = 1'b0;
    w_ram_in       = 1'b0;
    w_ir_in        = 1'b0;
    w_ir_out       = 1'b0;
    w_a_in         = 1'b0;
    w_a_out        = 1'b0;
    w_b_in         = 1'b0;
    w_alu_out      = 1'b0;
    w_sub          = 1'b0;
    w_update_flags = 1'b0;
    w_out_in       = 1'b0;
    case (r_STEP)
      c_T0: begin
        w_pc_out = 1'b1;
        w_mar_in = 1'b1;
      end
      c_T1: begin
        w_ram_out = 1'b1;
        w_ir_in   = 1'b1;
        w_pc_inc  = 1'b1;
      end
      c_T2: begin
        case (i_OPCODE)
          c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
            w_ir_out = 1'b1;
            w_mar_in = 1'b1;
          end
          c_OP_LDI: begin
            w_ir_out = 1'b1;
            w_a_in   = 1'b1;
          end
          c_OP_JMP: begin
            w_ir_out  = 1'b1;
            w_pc_load = 1'b1;
          end
          c_OP_JC: begin
            w_ir_out  = 1'b1;
            w_pc_load = i_CARRY_FLAG;
          end
          c_OP_JZ: begin
            w_ir_out  = 1'b1;
            w_pc_load = i_ZERO_FLAG;
          end
          c_OP_OUT: begin
            w_a_out  = 1'b1;
            w_out_in = 1'b1;
          end
          default: ;
        endcase
      end
      c_T3: begin
        case (i_OPCODE)
          c_OP_LDA: begin
            w_ram_out = 1'b1;
            w_a_in    = 1'b1;
          end
          c_OP_ADD, c_OP_SUB: begin
            // Subtract select is raised a step early so the ALU output is settled in T4.
            w_ram_out = 1'b1;
            w_b_in    = 1'b1;
            w_sub     = (i_OPCODE == c_OP_SUB);
          end
          c_OP_STA: begin
            w_a_out  = 1'b1;
            w_ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      c_T4: begin
        if (i_OPCODE == c_OP_ADD || i_OPCODE == c_OP_SUB) begin
          w_alu_out      = 1'b1;
          w_a_in         = 1'b1;
          w_update_flags = 1'b1;
          w_sub          = (i_OPCODE == c_OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign w_active = !i_CLEAR && i_ENABLE && !r_HALTED;

  assign o_PC_OUT_n       = ~(w_active & w_pc_out);
  assign o_PC_INC         =   w_active & w_pc_inc;
  assign o_PC_LOAD_n      = ~(w_active & w_pc_load);
  assign o_MAR_IN_n       = ~(w_active & w_mar_in);
  assign o_RAM_OUT_n      = ~(w_active & w_ram_out);
  assign o_RAM_IN_n       = ~(w_active & w_ram_in);
  assign o_IR_IN_n        = ~(w_active & w_ir_in);
  assign o_IR_OUT_n       = ~(w_active & w_ir_out);
  assign o_A_IN_n         = ~(w_active & w_a_in);
  assign o_A_OUT_n        = ~(w_active & w_a_out);
  assign o_B_IN_n         = ~(w_active & w_b_in);
  assign o_ALU_OUT_n      = ~(w_active & w_alu_out);
  assign o_SUB            =   w_active & w_sub;
  assign o_UPDATE_FLAGS_n = ~(w_active & w_update_flags);
  assign o_OUT_IN_n       = ~(w_active & w_out_in);
  assign o_HALTED         = r_HALTED;
  assign o_STEP           = r_STEP;

endmodule

`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
// ============================================================================
// Module   : tb_alu_control_sequencer
// Brief    : Directed self-checking bench for alu_control_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_control_sequencer;

  logic       i_CLOCK  = 1'b0;
  logic       i_CLEAR  = 1'b0;
  logic       i_ENABLE = 1'b0;
  logic [3:0] i_OPCODE = 4'd0;
  logic       i_ZERO_FLAG  = 1'b0;
  logic       i_CARRY_FLAG = 1'b0;
  logic o_PC_OUT_n, o_PC_INC, o_PC_LOAD_n, o_MAR_IN_n, o_RAM_OUT_n, o_RAM_IN_n;
  logic o_IR_IN_n, o_IR_OUT_n, o_A_IN_n, o_A_OUT_n, o_B_IN_n, o_ALU_OUT_n;
  logic o_SUB, o_UPDATE_FLAGS_n, o_OUT_IN_n, o_HALTED;
  logic [2:0] o_STEP;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe bit positions in the packed control word (active-high masks).
  localparam logic [14:0] M_PC_OUT  = 15'h4000;
  localparam logic [14:0] M_PC_INC  = 15'h2000;
  localparam logic [14:0] M_PC_LOAD = 15'h1000;
  localparam logic [14:0] M_MAR_IN  = 15'h0800;
  localparam logic [14:0] M_RAM_OUT = 15'h0400;
  localparam logic [14:0] M_RAM_IN  = 15'h0200;
  localparam logic [14:0] M_IR_IN   = 15'h0100;
  localparam logic [14:0] M_IR_OUT  = 15'h0080;
  localparam logic [14:0] M_A_IN    = 15'h0040;
  localparam logic [14:0] M_A_OUT   = 15'h0020;
  localparam logic [14:0] M_B_IN    = 15'h0010;
  localparam logic [14:0] M_ALU_OUT = 15'h0008;
  localparam logic [14:0] M_SUB     = 15'h0004;
  localparam logic [14:0] M_UPD     = 15'h0002;
  localparam logic [14:0] M_OUT_IN  = 15'h0001;
  localparam logic [14:0] IDLE      = 15'b101111111111011;
  localparam logic [14:0] FETCH0    = M_PC_OUT | M_MAR_IN;
  localparam logic [14:0] FETCH1    = M_RAM_OUT | M_IR_IN | M_PC_INC;

  logic [14:0] ctrl;
  assign ctrl = {o_PC_OUT_n, o_PC_INC, o_PC_LOAD_n, o_MAR_IN_n, o_RAM_OUT_n, o_RAM_IN_n,
                 o_IR_IN_n, o_IR_OUT_n, o_A_IN_n, o_A_OUT_n, o_B_IN_n, o_ALU_OUT_n,
                 o_SUB, o_UPDATE_FLAGS_n, o_OUT_IN_n};

  int drivers;
  assign drivers = int'(!o_PC_OUT_n) + int'(!o_RAM_OUT_n) + int'(!o_IR_OUT_n)
                 + int'(!o_A_OUT_n) + int'(!o_ALU_OUT_n);

  alu_control_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
    .i_CLOCK          (i_CLOCK),
    .i_CLEAR          (i_CLEAR),
    .i_ENABLE         (i_ENABLE),
    .i_OPCODE         (i_OPCODE),
    .i_ZERO_FLAG      (i_ZERO_FLAG),
    .i_CARRY_FLAG     (i_CARRY_FLAG),
    .o_PC_OUT_n       (o_PC_OUT_n),
    .o_PC_INC         (o_PC_INC),
    .o_PC_LOAD_n      (o_PC_LOAD_n),
    .o_MAR_IN_n       (o_MAR_IN_n),
    .o_RAM_OUT_n      (o_RAM_OUT_n),
    .o_RAM_IN_n       (o_RAM_IN_n),
    .o_IR_IN_n        (o_IR_IN_n),
    .o_IR_OUT_n       (o_IR_OUT_n),
    .o_A_IN_n         (o_A_IN_n),
    .o_A_OUT_n        (o_A_OUT_n),
    .o_B_IN_n         (o_B_IN_n),
    .o_ALU_OUT_n      (o_ALU_OUT_n),
    .o_SUB            (o_SUB),
    .o_UPDATE_FLAGS_n (o_UPDATE_FLAGS_n),
    .o_OUT_IN_n       (o_OUT_IN_n),
    .o_HALTED         (o_HALTED),
    .o_STEP           (o_STEP)
  );

  always #5 i_CLOCK = ~i_CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLOCK);
    #2;
  endtask

  // Check step number and strobes of the current step, then advance one edge.
  task automatic expect_step(input string tag, input int st, input logic [14:0] mask);
    chk({tag, "_step"}, 32'(o_STEP), 32'(st));
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(IDLE ^ mask));
    chk({tag, "_drv"}, 32'(drivers <= 1), 32'd1);
    tick();
  endtask

  initial begin
    #1 i_CLEAR = 1'b1;
    #1;
    chk("rst_step", 32'(o_STEP), 32'd0);
    chk("rst_halted", 32'(o_HALTED), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'(IDLE));
    i_ENABLE = 1'b1;
    tick();
    chk("rst_en_ctrl", 32'(ctrl), 32'(IDLE));
    chk("rst_en_step", 32'(o_STEP), 32'd0);
    i_CLEAR = 1'b0;
    #1;

    // LDA interrupted by clear in T3
    i_OPCODE = 4'd1;
    expect_step("lda_t0", 0, FETCH0);
    expect_step("lda_t1", 1, FETCH1);
    expect_step("lda_t2", 2, M_IR_OUT | M_MAR_IN);
    chk("lda_t3_step", 32'(o_STEP), 32'd3);
    chk("lda_t3_ctrl", 32'(ctrl), 32'(IDLE ^ (M_RAM_OUT | M_A_IN)));
    i_CLEAR = 1'b1;
    #1;
    chk("clr_mid_step", 32'(o_STEP), 32'd0);
    chk("clr_mid_ctrl", 32'(ctrl), 32'(IDLE));
    tick();
    i_CLEAR = 1'b0;
    #1;
    expect_step("restart_t0", 0, FETCH0);
    expect_step("restart_t1", 1, FETCH1);
    i_CLEAR = 1'b1;
    #1 i_CLEAR = 1'b0;
    #1;

    // ADD
    i_OPCODE = 4'd2;
    expect_step("add_t0", 0, FETCH0);
    expect_step("add_t1", 1, FETCH1);
    expect_step("add_t2", 2, M_IR_OUT | M_MAR_IN);
    expect_step("add_t3", 3, M_RAM_OUT | M_B_IN);
    expect_step("add_t4", 4, M_ALU_OUT | M_A_IN | M_UPD);
    chk("add_wrap", 32'(o_STEP), 32'd0);

    // SUB
    i_OPCODE = 4'd3;
    expect_step("sub_t0", 0, FETCH0);
    expect_step("sub_t1", 1, FETCH1);
    expect_step("sub_t2", 2, M_IR_OUT | M_MAR_IN);
    expect_step("sub_t3", 3, M_RAM_OUT | M_B_IN | M_SUB);
    expect_step("sub_t4", 4, M_ALU_OUT | M_A_IN | M_UPD | M_SUB);
    chk("sub_wrap", 32'(o_STEP), 32'd0);

    // STA, LDI, JMP, OUT
    i_OPCODE = 4'd4;
    expect_step("sta_t0", 0, FETCH0);
    expect_step("sta_t1", 1, FETCH1);
    expect_step("sta_t2", 2, M_IR_OUT | M_MAR_IN);
    expect_step("sta_t3", 3, M_A_OUT | M_RAM_IN);
    i_OPCODE = 4'd5;
    expect_step("ldi_t0", 0, FETCH0);
    expect_step("ldi_t1", 1, FETCH1);
    expect_step("ldi_t2", 2, M_IR_OUT | M_A_IN);
    i_OPCODE = 4'd6;
    expect_step("jmp_t0", 0, FETCH0);
    expect_step("jmp_t1", 1, FETCH1);
    expect_step("jmp_t2", 2, M_IR_OUT | M_PC_LOAD);
    i_OPCODE = 4'd14;
    expect_step("out_t0", 0, FETCH0);
    expect_step("out_t1", 1, FETCH1);
    expect_step("out_t2", 2, M_A_OUT | M_OUT_IN);

    // Conditional jumps: each flag tested in both polarities, the other flag opposite.
    for (int f = 0; f < 2; f++) begin
      i_OPCODE = 4'd7;
      i_CARRY_FLAG = f[0];
      i_ZERO_FLAG  = ~f[0];
      expect_step("jc_t0", 0, FETCH0);
      expect_step("jc_t1", 1, FETCH1);
      expect_step("jc_t2", 2, f[0] ? (M_IR_OUT | M_PC_LOAD) : M_IR_OUT);
      i_OPCODE = 4'd8;
      i_ZERO_FLAG  = f[0];
      i_CARRY_FLAG = ~f[0];
      expect_step("jz_t0", 0, FETCH0);
      expect_step("jz_t1", 1, FETCH1);
      expect_step("jz_t2", 2, f[0] ? (M_IR_OUT | M_PC_LOAD) : M_IR_OUT);
      chk("jz_wrap", 32'(o_STEP), 32'd0);
    end
    i_ZERO_FLAG  = 1'b0;
    i_CARRY_FLAG = 1'b0;

    // Enable pause at T1, then undefined opcode as NOP
    i_OPCODE = 4'd11;
    expect_step("nop_t0", 0, FETCH0);
    i_ENABLE = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("pause_step", 32'(o_STEP), 32'd1);
      chk("pause_ctrl", 32'(ctrl), 32'(IDLE));
      tick();
    end
    i_ENABLE = 1'b1;
    #1;
    expect_step("nop_t1", 1, FETCH1);
    expect_step("nop_t2", 2, 15'h0000);
    chk("nop_wrap", 32'(o_STEP), 32'd0);

    // HLT
    i_OPCODE = 4'd15;
    expect_step("hlt_t0", 0, FETCH0);
    expect_step("hlt_t1", 1, FETCH1);
    expect_step("hlt_t2", 2, 15'h0000);
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", 32'(o_HALTED), 32'd1);
      chk("halt_step", 32'(o_STEP), 32'd2);
      chk("halt_ctrl", 32'(ctrl), 32'(IDLE));
      i_ENABLE = i[0];
      tick();
    end
    i_ENABLE = 1'b1;
    i_CLEAR = 1'b1;
    #1;
    chk("unhalt_flag", 32'(o_HALTED), 32'd0);
    chk("unhalt_step", 32'(o_STEP), 32'd0);
    tick();
    i_CLEAR = 1'b0;
    i_OPCODE = 4'd0;
    #1;
    expect_step("post_t0", 0, FETCH0);
    expect_step("post_t1", 1, FETCH1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
